// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline definitions: write-back source select, load funct3 codes,
// write-back FSM states and the register-write qualification helper.
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_NONE = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_WAIT_LD = 1'b1
    } wb_state_e;

    // x0 is hardwired to zero, so writes to it are dropped along with explicit no-writes.
    function automatic logic wr_allowed(input logic we, input wb_sel_e sel, input logic rd_nz);
        return we && (sel != WB_NONE) && rd_nz;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half lane from an aligned memory
// word and sign- or zero-extends it according to the load funct3.
module load_align
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result = raw;
        byte_v = raw[{off, 3'b000} +: 8];
        half_v = off[1] ? raw[31:16] : raw[15:0];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LH:   result = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_v};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, half_v};
            default: result = raw;  // LW and reserved codes take the full word
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: registers ALU/PC+4 results and waits for load data.
// Defining WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass outputs for decode.
module wb_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_rd_we,
    input  logic [1:0]        in_wb_sel,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic [2:0]        in_ld_funct3,
    input  logic [1:0]        in_ld_off,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   rd_wr_data,
    output logic              rd_wr_en,
    output logic              busy
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [XLEN-1:0]   fwd_data
`endif
);

    wb_state_e         state;
    wb_sel_e           sel;
    logic [REG_AW-1:0] ld_rd;
    logic [2:0]        ld_funct3;
    logic [1:0]        ld_off;
    logic              ld_we;
    logic [XLEN-1:0]   ld_data;

    assign sel      = wb_sel_e'(in_wb_sel);
    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_WAIT_LD);

    // Lane selection uses the latched load fields, since the memory word arrives later.
    load_align #(.XLEN(XLEN)) u_load_align (
        .raw    (dmem_rdata),
        .funct3 (ld_funct3),
        .off    (ld_off),
        .result (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rd         <= '0;
            rd_wr_data <= '0;
            rd_wr_en   <= 1'b0;
            ld_rd      <= '0;
            ld_funct3  <= '0;
            ld_off     <= '0;
            ld_we      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge, order-independent.
            rd_wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (sel == WB_LOAD) begin
                            ld_rd     <= in_rd;
                            ld_funct3 <= in_ld_funct3;
                            ld_off    <= in_ld_off;
                            ld_we     <= wr_allowed(in_rd_we, sel, in_rd != '0);
                            state     <= ST_WAIT_LD;
                        end else if (wr_allowed(in_rd_we, sel, in_rd != '0)) begin
                            rd         <= in_rd;
                            rd_wr_data <= (sel == WB_PC4) ? in_pc4 : in_alu_res;
                            rd_wr_en   <= 1'b1;
                        end
                    end
                end
                ST_WAIT_LD: begin
                    if (dmem_rvalid) begin
                        if (ld_we) begin
                            rd         <= ld_rd;
                            rd_wr_data <= ld_data;
                            rd_wr_en   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = rd_wr_en;
    assign fwd_rd    = rd;
    assign fwd_data  = rd_wr_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a table of single instructions (ALU, PC+4, loads)
// plus hand sequences for reset, back-to-back writes, idle rvalid and reset mid-load.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_pc4;
    logic [2:0]  in_ld_funct3;
    logic [1:0]  in_ld_off;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rd;
    logic [31:0] rd_wr_data;
    logic        rd_wr_en;
    logic        busy;
`ifdef WB_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    wb_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rd        (in_rd),
        .in_rd_we     (in_rd_we),
        .in_wb_sel    (in_wb_sel),
        .in_alu_res   (in_alu_res),
        .in_pc4       (in_pc4),
        .in_ld_funct3 (in_ld_funct3),
        .in_ld_off    (in_ld_off),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata),
        .rd           (rd),
        .rd_wr_data   (rd_wr_data),
        .rd_wr_en     (rd_wr_en),
        .busy         (busy)
`ifdef WB_FWD_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd_we;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdata;
        logic        exp_en;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic en, input logic [4:0] r, input logic [31:0] d);
        check({tag, " wr_en"}, {31'd0, rd_wr_en}, {31'd0, en});
        check({tag, " rd"}, {27'd0, rd}, {27'd0, r});
        check({tag, " data"}, rd_wr_data, d);
`ifdef WB_FWD_EN
        check({tag, " fwd_valid"}, {31'd0, fwd_valid}, {31'd0, en});
        check({tag, " fwd_rd"}, {27'd0, fwd_rd}, {27'd0, r});
        check({tag, " fwd_data"}, fwd_data, d);
`endif
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] r, input logic [1:0] s,
                         input logic [31:0] alu, input logic [31:0] pc4);
        in_valid   = v;
        in_rd_we   = we;
        in_rd      = r;
        in_wb_sel  = s;
        in_alu_res = alu;
        in_pc4     = pc4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction: accept, and for loads return data two cycles after acceptance.
    task automatic apply(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        check({tag, " ready before"}, {31'd0, in_ready}, 32'd1);
        drive(1'b1, v.rd_we, v.rd, v.sel, v.alu, v.pc4);
        in_ld_funct3 = v.f3;
        in_ld_off    = v.off;
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
        if (v.sel == 2'b01) begin
            check({tag, " busy wait"}, {31'd0, busy}, 32'd1);
            check({tag, " ready wait"}, {31'd0, in_ready}, 32'd0);
            check({tag, " wr_en wait"}, {31'd0, rd_wr_en}, 32'd0);
            tick();
            check({tag, " ready wait2"}, {31'd0, in_ready}, 32'd0);
            dmem_rvalid = 1'b1;
            dmem_rdata  = v.rdata;
            tick();
            dmem_rvalid = 1'b0;
            dmem_rdata  = 32'hA5A5_A5A5;
            check({tag, " ready after"}, {31'd0, in_ready}, 32'd1);
        end
        check_outputs(tag, v.exp_en, v.exp_rd, v.exp_data);
    endtask

    initial begin
        // rd_we rd     sel    f3      off    alu            pc4         rdata          en    rd      data
        vecs[0]  = '{1'b1, 5'd5,  2'b00, 3'b000, 2'd0, 32'h0000_1234, 32'h0,      32'h0,         1'b1, 5'd5,  32'h0000_1234};
        vecs[1]  = '{1'b1, 5'd7,  2'b01, 3'b000, 2'd3, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd7,  32'hFFFF_FF80};
        vecs[2]  = '{1'b1, 5'd8,  2'b01, 3'b101, 2'd2, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd8,  32'h0000_80FF};
        vecs[3]  = '{1'b1, 5'd9,  2'b01, 3'b001, 2'd2, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd9,  32'hFFFF_80FF};
        vecs[4]  = '{1'b1, 5'd10, 2'b01, 3'b010, 2'd1, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd10, 32'h80FF_7F01};
        vecs[5]  = '{1'b1, 5'd11, 2'b01, 3'b100, 2'd2, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd11, 32'h0000_00FF};
        vecs[6]  = '{1'b1, 5'd12, 2'b01, 3'b000, 2'd1, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd12, 32'h0000_007F};
        vecs[7]  = '{1'b1, 5'd13, 2'b01, 3'b001, 2'd0, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd13, 32'h0000_7F01};
        vecs[8]  = '{1'b1, 5'd14, 2'b01, 3'b011, 2'd2, 32'h0,         32'h0,      32'h80FF_7F01, 1'b1, 5'd14, 32'h80FF_7F01};
        vecs[9]  = '{1'b1, 5'd0,  2'b10, 3'b000, 2'd0, 32'h0,         32'h44,     32'h0,         1'b0, 5'd14, 32'h80FF_7F01};
        vecs[10] = '{1'b1, 5'd1,  2'b10, 3'b000, 2'd0, 32'h0000_0077, 32'h44,     32'h0,         1'b1, 5'd1,  32'h0000_0044};
        vecs[11] = '{1'b1, 5'd3,  2'b11, 3'b000, 2'd0, 32'h0000_0055, 32'h0,      32'h0,         1'b0, 5'd1,  32'h0000_0044};
        vecs[12] = '{1'b0, 5'd4,  2'b00, 3'b000, 2'd0, 32'h0000_0099, 32'h0,      32'h0,         1'b0, 5'd1,  32'h0000_0044};
        vecs[13] = '{1'b0, 5'd6,  2'b01, 3'b010, 2'd0, 32'h0,         32'h0,      32'h1111_2222, 1'b0, 5'd1,  32'h0000_0044};
        vecs[14] = '{1'b1, 5'd0,  2'b01, 3'b010, 2'd0, 32'h0,         32'h0,      32'h3333_4444, 1'b0, 5'd1,  32'h0000_0044};
        vecs[15] = '{1'b1, 5'd31, 2'b00, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0,      32'h0,         1'b1, 5'd31, 32'hDEAD_BEEF};

        rst_n        = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
        in_ld_funct3 = 3'b000;
        in_ld_off    = 2'd0;
        dmem_rvalid  = 1'b0;
        dmem_rdata   = 32'd0;
        repeat (2) tick();
        check_outputs("reset", 1'b0, 5'd0, 32'd0);
        check("reset ready", {31'd0, in_ready}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) apply(i, vecs[i]);

        // rvalid while idle must not produce a write.
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h0BAD_0BAD;
        tick();
        dmem_rvalid = 1'b0;
        check_outputs("idle rvalid", 1'b0, 5'd31, 32'hDEAD_BEEF);
        check("idle rvalid ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back ALU writes to x1, x2, x3.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 5'(i), 2'b00, 32'h100 + 32'(i), 32'd0);
            tick();
            check_outputs($sformatf("b2b%0d", i), 1'b1, 5'(i), 32'h100 + 32'(i));
        end
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
        tick();
        check_outputs("b2b idle", 1'b0, 5'd3, 32'h0000_0103);

        // x0 write is dropped but the following instruction is taken the very next cycle.
        drive(1'b1, 1'b1, 5'd0, 2'b10, 32'd0, 32'h44);
        tick();
        check_outputs("x0 pc4", 1'b0, 5'd3, 32'h0000_0103);
        check("x0 ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 1'b1, 5'd4, 2'b00, 32'h0000_0404, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
        check_outputs("after x0", 1'b1, 5'd4, 32'h0000_0404);

        // Reset while a load is pending discards it.
        drive(1'b1, 1'b1, 5'd7, 2'b01, 32'd0, 32'd0);
        in_ld_funct3 = 3'b010;
        tick();
        drive(1'b0, 1'b0, 5'd0, 2'b00, 32'd0, 32'd0);
        check("rst ld busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("rst async", 1'b0, 5'd0, 32'd0);
        check("rst async ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        check_outputs("rst discard", 1'b0, 5'd0, 32'd0);
        check("rst discard ready", {31'd0, in_ready}, 32'd1);
        check("rst discard busy", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
